// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first,
// repeat_cnt+1 times, with GAP idle cycles between repetitions and a done pulse.
module seq_pattern_tx #(
    parameter int PAT_W = 5,
    parameter int GAP   = 1,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             ready,
    output logic             dataout,
    output logic             dout_valid,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : {GAP_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state_r;
    logic [PAT_W-1:0] pat_r;
    logic [CNT_W-1:0] rep_r;
    logic [IDX_W-1:0] idx_r;
    logic [GAP_W-1:0] gap_r;
    logic             ready_r;
    logic             dout_r;
    logic             valid_r;
    logic             done_r;

    logic [IDX_W-1:0] idx_dec_s;
    logic             last_bit_s;
    logic             reps_left_s;
    logic             gap_end_s;

    // idx_r names the bit currently on dataout; these flag where the sequence goes next
    always_comb begin
        idx_dec_s   = idx_r - IDX_W'(1);
        last_bit_s  = (idx_r == {IDX_W{1'b0}});
        reps_left_s = (rep_r != {CNT_W{1'b0}});
        gap_end_s   = (gap_r == {GAP_W{1'b0}});
    end

    // Transmit FSM with registered outputs; abort and reset both land in S_IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            pat_r   <= {PAT_W{1'b0}};
            rep_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            gap_r   <= {GAP_W{1'b0}};
            ready_r <= 1'b1;
            dout_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !abort) begin
                        state_r <= S_SEND;
                        pat_r   <= pattern;
                        rep_r   <= repeat_cnt;
                        idx_r   <= IDX_MSB;
                        ready_r <= 1'b0;
                        dout_r  <= pattern[PAT_W-1];
                        valid_r <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                        dout_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                        rep_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        gap_r   <= {GAP_W{1'b0}};
                        ready_r <= 1'b1;
                        dout_r  <= 1'b0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (!last_bit_s) begin
                        idx_r   <= idx_dec_s;
                        dout_r  <= pat_r[idx_dec_s];
                        valid_r <= 1'b1;
                    end else if (reps_left_s) begin
                        // Down-counter stops at zero, so a maximal repeat_cnt never wraps
                        rep_r <= rep_r - CNT_W'(1);
                        if (GAP == 0) begin
                            idx_r   <= IDX_MSB;
                            dout_r  <= pat_r[PAT_W-1];
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= S_GAP;
                            gap_r   <= GAP_LAST;
                            dout_r  <= 1'b0;
                            valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= S_FINISH;
                        done_r  <= 1'b1;
                        dout_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                        rep_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        gap_r   <= {GAP_W{1'b0}};
                        ready_r <= 1'b1;
                        dout_r  <= 1'b0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (gap_end_s) begin
                        state_r <= S_SEND;
                        idx_r   <= IDX_MSB;
                        dout_r  <= pat_r[PAT_W-1];
                        valid_r <= 1'b1;
                    end else begin
                        gap_r   <= gap_r - GAP_W'(1);
                        dout_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                S_FINISH: begin
                    state_r <= S_IDLE;
                    rep_r   <= {CNT_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                    gap_r   <= {GAP_W{1'b0}};
                    ready_r <= 1'b1;
                    dout_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    rep_r   <= {CNT_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                    gap_r   <= {GAP_W{1'b0}};
                    ready_r <= 1'b1;
                    dout_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_r;
    assign dataout    = dout_r;
    assign dout_valid = valid_r;
    assign done       = done_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed scoreboard bench for seq_pattern_tx: one GAP=1 instance and one GAP=0
// instance whose serial stream drives a reference 11101 Mealy detector.
module tb_seq_pattern_tx;

    logic       clock;
    logic       reset;
    logic       start,  start0;
    logic [4:0] pattern, pattern0;
    logic [2:0] repeat_cnt, repeat_cnt0;
    logic       abort,  abort0;
    logic       ready,  ready0;
    logic       dataout, dataout0;
    logic       dout_valid, dout_valid0;
    logic       done,   done0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic dv;
        logic d;
        logic dn;
        logic rdy;
        logic flag;
    } exp_t;

    exp_t sb_q[$];

    seq_pattern_tx #(.PAT_W(5), .GAP(1), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .abort(abort), .ready(ready),
        .dataout(dataout), .dout_valid(dout_valid), .done(done)
    );

    seq_pattern_tx #(.PAT_W(5), .GAP(0), .CNT_W(3)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .pattern(pattern0),
        .repeat_cnt(repeat_cnt0), .abort(abort0), .ready(ready0),
        .dataout(dataout0), .dout_valid(dout_valid0), .done(done0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference overlapping 11101 Mealy detector on the GAP=0 serial stream
    logic [2:0] det_st;
    logic       det_flag;
    always_comb det_flag = dout_valid0 && (det_st == 3'd4) && dataout0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) det_st <= 3'd0;
        else if (!dout_valid0) det_st <= 3'd0;
        else begin
            case (det_st)
                3'd0:    det_st <= dataout0 ? 3'd1 : 3'd0;
                3'd1:    det_st <= dataout0 ? 3'd2 : 3'd0;
                3'd2:    det_st <= dataout0 ? 3'd3 : 3'd0;
                3'd3:    det_st <= dataout0 ? 3'd3 : 3'd4;
                3'd4:    det_st <= dataout0 ? 3'd1 : 3'd0;
                default: det_st <= 3'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic push_rec(input logic dv, input logic d, input logic dn,
                            input logic rdy, input logic flag);
        exp_t e;
        e.dv = dv; e.d = d; e.dn = dn; e.rdy = rdy; e.flag = flag;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Expected per-cycle output from T+1: bits, gaps, FINISH, then one IDLE cycle
    task automatic push_stream(input logic [4:0] pat, input int reps, input int gap);
        logic [4:0] p;
        p = pat;
        for (int r = 0; r <= reps; r++) begin
            for (int k = 0; k < 5; k++)
                push_rec(1'b1, p[4-k], 1'b0, 1'b0, (k == 4) ? 1'b1 : 1'b0);
            if (r < reps)
                for (int g = 0; g < gap; g++) push_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        push_rec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_idle(1);
    endtask

    // kind 1: junk start with pattern 0; kind 2: abort -- applied at cycle inj
    task automatic drain(input string tag, input int inj, input int kind);
        exp_t e;
        int cyc;
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) start = 1'b0;
            e = sb_q.pop_front();
            chk({tag, "_valid"}, dout_valid, e.dv);
            chk({tag, "_data"},  dataout,    e.d);
            chk({tag, "_done"},  done,       e.dn);
            chk({tag, "_ready"}, ready,      e.rdy);
            if (cyc == inj) begin
                if (kind == 1) begin start = 1'b1; pattern = 5'b00000; repeat_cnt = 3'd0; end
                if (kind == 2) abort = 1'b1;
            end
            if (cyc == inj + 1) begin
                start = 1'b0;
                abort = 1'b0;
            end
        end
    endtask

    task automatic drain0(input string tag);
        exp_t e;
        int cyc;
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) start0 = 1'b0;
            e = sb_q.pop_front();
            chk({tag, "_valid"}, dout_valid0, e.dv);
            chk({tag, "_data"},  dataout0,    e.d);
            chk({tag, "_done"},  done0,       e.dn);
            chk({tag, "_ready"}, ready0,      e.rdy);
            chk({tag, "_detect"}, det_flag,   e.flag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0; pattern = 5'b00000; repeat_cnt = 3'd0; abort = 1'b0;
        start0 = 1'b0; pattern0 = 5'b00000; repeat_cnt0 = 3'd0; abort0 = 1'b0;

        #12;
        chk("rst_ready", ready, 1'b1);
        chk("rst_data", dataout, 1'b0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready0", ready0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        push_idle(2);
        drain("idle", 0, 0);

        // Single transmission of 11101
        pattern = 5'b11101; repeat_cnt = 3'd0; start = 1'b1;
        push_stream(5'b11101, 0, 1);
        drain("single", 0, 0);

        // Back-to-back start in the first IDLE cycle after FINISH
        pattern = 5'b10010; repeat_cnt = 3'd0; start = 1'b1;
        push_stream(5'b10010, 0, 1);
        drain("b2b", 0, 0);

        // One repeat with a one-cycle gap
        pattern = 5'b11101; repeat_cnt = 3'd1; start = 1'b1;
        push_stream(5'b11101, 1, 1);
        drain("rep1", 0, 0);

        // Start with pattern 00000 during the transfer is ignored
        pattern = 5'b11101; repeat_cnt = 3'd0; start = 1'b1;
        push_stream(5'b11101, 0, 1);
        drain("ignore", 2, 1);

        // Abort during the third bit: idle from T+4, no done pulse
        pattern = 5'b11101; repeat_cnt = 3'd2; start = 1'b1;
        push_rec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_rec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_rec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_idle(4);
        drain("abort", 3, 2);

        // Abort beats start in IDLE
        pattern = 5'b11111; repeat_cnt = 3'd0; start = 1'b1; abort = 1'b1;
        push_idle(2);
        drain("abort_pri", 0, 0);
        abort = 1'b0;

        // Maximum repeat count: eight transmissions, no wrap
        pattern = 5'b10110; repeat_cnt = 3'd7; start = 1'b1;
        push_stream(5'b10110, 7, 1);
        drain("maxrep", 0, 0);

        // Asynchronous reset between edges while sending
        pattern = 5'b11101; repeat_cnt = 3'd3; start = 1'b1;
        push_rec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_rec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("pre_rst", 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_valid", dout_valid, 1'b0);
        chk("arst_data", dataout, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        push_idle(8);
        drain("post_rst", 0, 0);
        pattern = 5'b11101; repeat_cnt = 3'd0; start = 1'b1;
        push_stream(5'b11101, 0, 1);
        drain("after_rst", 0, 0);

        // GAP=0 instance, three repetitions into the 11101 detector
        pattern0 = 5'b11101; repeat_cnt0 = 3'd2; start0 = 1'b1;
        push_stream(5'b11101, 2, 0);
        drain0("gap0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 5: pattern length in bits.
REQ-002 SHALL have parameter GAP, default 1: idle cycles inserted between repeated transmissions; 0 means no gap.
REQ-003 SHALL have parameter CNT_W, default 3: width of repeat_cnt.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to transmit; accepted only when start=1 and ready=1 at a rising edge.
REQ-007 SHALL have port pattern  input  PAT_W  bit pattern to send, MSB first; default use 5'b11101.
REQ-008 SHALL have port repeat_cnt  input  CNT_W  number of extra repetitions; total transmissions = repeat_cnt+1.
REQ-009 SHALL have port abort  input  1  terminates any transfer in progress.
REQ-010 SHALL have port ready  output  1  high only in IDLE.
REQ-011 SHALL have port dataout  output  1  serial data bit, registered.
REQ-012 SHALL have port dout_valid  output  1  high when dataout carries a pattern bit, registered.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-014 SHALL implement states IDLE, SEND, GAP, FINISH.
REQ-015 SHALL, on acceptance at edge T, latch pattern and repeat_cnt and enter SEND; ready=0 from T+1.
REQ-016 SHALL drive dataout=pattern[PAT_W-1-k], dout_valid=1 in cycle T+1+k, for k = 0..PAT_W-1.
REQ-017 SHALL keep a bit index counter and a repeat down-counter; the repeat counter decrements once per completed pattern.
REQ-018 SHALL, after the last bit with repeats remaining, enter GAP for GAP cycles (dataout=0, dout_valid=0), then SEND again from the MSB.
REQ-019 SHALL, with GAP=0, begin the next repetition's MSB in the cycle immediately after the previous LSB.
REQ-020 SHALL, after the last bit of the final repetition, enter FINISH for one cycle: done=1, dout_valid=0, dataout=0; then return to IDLE.
REQ-021 SHALL ignore start while not in IDLE; latched pattern and count are not modified mid-transfer.
REQ-022 SHALL, on abort=1 at an edge in SEND, GAP or FINISH, go to IDLE next cycle with dataout=0, dout_valid=0, done=0.
REQ-023 SHALL give abort priority over start in IDLE: start is not accepted when abort=1.
REQ-024 SHALL accept a new start in the first IDLE cycle after FINISH, giving back-to-back transfers with one ready cycle between them.
REQ-025 SHALL treat repeat_cnt at its maximum value (2^CNT_W-1) as 2^CNT_W transmissions, with no counter wrap-around.
REQ-026 SHALL hold dataout=0, dout_valid=0, done=0 throughout IDLE.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state=IDLE, ready=1, dataout=0, dout_valid=0, done=0, and clear all counters.
REQ-028 SHALL, on reset asserted mid-transfer, abandon the transfer without a done pulse; after release it is in IDLE and accepts start normally.

Verification
REQ-029 SHALL verify: pattern=11101, repeat_cnt=0, start at T -> dataout 1,1,1,0,1 with dout_valid=1 at T+1..T+5; done=1 at T+6; ready=1 at T+7.
REQ-030 SHALL verify: pattern=11101, repeat_cnt=1, GAP=1 -> bits at T+1..T+5, dout_valid=0 at T+6, bits again at T+7..T+11, done at T+12.
REQ-031 SHALL verify: abort=1 at T+3 during the first transfer -> dout_valid=0 and ready=1 from T+4, and no done pulse.
REQ-032 SHALL verify: start pulses with pattern=00000 at T+2 during a transfer -> ignored, and the output stream is still 11101.
REQ-033 SHALL verify: reset=0 asserted asynchronously between edges in SEND -> outputs zero and ready=1 immediately; start after release gives a correct 11101 stream.
REQ-034 SHALL verify: the serial output fed into the team's 11101 Mealy detector with repeat_cnt=2, GAP=0 -> detector flags at the final bit of each repetition.
